mac_seq_ctrl: RTL

Sequencer for the MAC datapath. It accepts a dot-product job (length plus two operand base addresses), generates operand read addresses and strobes, and drives the clock-enables and clear of the multiplier and accumulator pipeline registers. It holds the result valid until downstream accepts it. It sits between the job issuer and the MAC datapath, whose pipeline registers are ce-gated, reset-capable DFF stages.

---
 rtl/mac_seq_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the MAC datapath: operand address/strobe generation plus multiplier/accumulator enables.
// Optional job cancel (abort/aborted ports) is built when MAC_SEQ_ABORT_EN is defined.
module mac_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int PIPE   = 2
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [ADDR_W-1:0] i_base_a,
  input  logic [ADDR_W-1:0] i_base_b,
  output logic              o_busy,
  output logic              o_err_len0,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr_a,
  output logic [ADDR_W-1:0] o_addr_b,
  output logic              o_mul_ce,
  output logic              o_acc_clr,
  output logic              o_acc_ce,
  output logic              o_out_valid,
`ifdef MAC_SEQ_ABORT_EN
  input  logic              i_abort,
  output logic              o_aborted,
`endif
  input  logic              i_out_ready
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_DRAIN, S_HOLD} state_t;
  localparam int DW = $clog2(PIPE) + 1;

  state_t            r_state;
  logic [LEN_W-1:0]  r_cnt;
  logic [DW-1:0]     r_drain;
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [PIPE-1:0]   r_pipe;
  logic              r_rd_en;
  logic              r_acc_clr;
  logic              r_out_valid;
  logic              r_err_len0;
  logic              w_abort;

`ifdef MAC_SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort   = i_abort && (r_state != S_IDLE);
  assign o_aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_pipe      <= '0;
      r_rd_en     <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_len0  <= 1'b0;
`ifdef MAC_SEQ_ABORT_EN
      r_aborted   <= 1'b0;
`endif
    end else begin
      r_err_len0 <= 1'b0;
      r_pipe     <= {r_pipe[PIPE-2:0], r_rd_en};
`ifdef MAC_SEQ_ABORT_EN
      r_aborted  <= 1'b0;
`endif
      if (w_abort) begin
        // Flushing the pipe tracker suppresses any enables still in flight.
        r_state     <= S_IDLE;
        r_pipe      <= '0;
        r_rd_en     <= 1'b0;
        r_acc_clr   <= 1'b0;
        r_out_valid <= 1'b0;
`ifdef MAC_SEQ_ABORT_EN
        r_aborted   <= 1'b1;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              if (i_len == '0) begin
                r_err_len0 <= 1'b1;
              end else begin
                r_cnt     <= i_len - LEN_W'(1);
                r_base_a  <= i_base_a;
                r_base_b  <= i_base_b;
                r_acc_clr <= 1'b1;
                r_state   <= S_CLR;
              end
            end
          end
          S_CLR: begin
            r_acc_clr <= 1'b0;
            r_rd_en   <= 1'b1;
            r_addr_a  <= r_base_a;
            r_addr_b  <= r_base_b;
            r_state   <= S_RUN;
          end
          S_RUN: begin
            // r_cnt holds the number of reads still to issue after this one.
            if (r_cnt == '0) begin
              r_rd_en <= 1'b0;
              r_drain <= DW'(PIPE - 1);
              r_state <= S_DRAIN;
            end else begin
              r_cnt    <= r_cnt - LEN_W'(1);
              r_addr_a <= r_addr_a + ADDR_W'(1);
              r_addr_b <= r_addr_b + ADDR_W'(1);
            end
          end
          S_DRAIN: begin
            if (r_drain == '0) begin
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else begin
              r_drain <= r_drain - DW'(1);
            end
          end
          S_HOLD: begin
            if (i_out_ready) begin
              r_out_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_err_len0  = r_err_len0;
  assign o_rd_en     = r_rd_en;
  assign o_addr_a    = r_addr_a;
  assign o_addr_b    = r_addr_b;
  assign o_mul_ce    = r_pipe[PIPE-2];
  assign o_acc_ce    = r_pipe[PIPE-1];
  assign o_acc_clr   = r_acc_clr;
  assign o_out_valid = r_out_valid;

endmodule
